// File: rtl/i2c_cmd_sequencer.sv
// I2C command sequencer: queues bus-side commands, issues them one at a time to the PHY and
// collects completions. Define I2C_SEQ_TIMEOUT_EN to enable the WAIT-state watchdog.
module i2c_cmd_sequencer #(
   parameter int CMD_DEPTH      = 4,
   parameter int RSP_DEPTH      = 4,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic        i2c_clock_i,
   input  logic        i2c_resetn_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic [1:0]  cmd_tx_size_i,
   input  logic [1:0]  cmd_rx_size_i,
   input  logic [31:0] cmd_tx_data_i,
   input  logic [21:0] clkdiv_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rx_data_o,
   output logic        rsp_abort_o,
   output logic        err_o,
   input  logic        err_clr_i,
   output logic        seq_busy_o,
   output logic [1:0]  i2c_tx_size_o,
   output logic [1:0]  i2c_rx_size_o,
   output logic [31:0] i2c_tx_data_o,
   output logic [21:0] i2c_clkdiv_o,
   output logic        i2c_valid_o,
   input  logic        i2c_done_i,
   input  logic        i2c_busy_i,
   input  logic [31:0] i2c_rx_data_i,
   input  logic        i2c_abort_i
);

   localparam int CAW   = $clog2(CMD_DEPTH);
   localparam int RAW   = $clog2(RSP_DEPTH);
   localparam int CMD_W = 36;

   if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0 ||
       RSP_DEPTH < 2 || (RSP_DEPTH & (RSP_DEPTH - 1)) != 0 ||
       TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("i2c_cmd_sequencer: illegal parameter value");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t           state_q;
   logic [CMD_W-1:0] cmd_mem_q [CMD_DEPTH];
   logic [CAW:0]     cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
   logic [32:0]      rsp_mem_q [RSP_DEPTH];
   logic [RAW:0]     rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d;
   logic             err_q, err_d;
   logic             rdy_en_q;
   logic [1:0]       tx_size_q, rx_size_q;
   logic [31:0]      tx_data_q;
   logic [21:0]      clkdiv_q;
   logic             valid_q;

   logic             cmd_empty, cmd_full, cmd_push;
   logic             rsp_empty, rsp_full, rsp_push, rsp_pop;
   logic             go, wait_done, timeout, flush;
   logic [32:0]      rsp_wdata, rsp_head;
   logic [CMD_W-1:0] cmd_head;

   assign cmd_empty = (cmd_wr_q == cmd_rd_q);
   assign cmd_full  = (cmd_wr_q[CAW] != cmd_rd_q[CAW]) &&
                      (cmd_wr_q[CAW-1:0] == cmd_rd_q[CAW-1:0]);
   assign rsp_empty = (rsp_wr_q == rsp_rd_q);
   assign rsp_full  = (rsp_wr_q[RAW] != rsp_rd_q[RAW]) &&
                      (rsp_wr_q[RAW-1:0] == rsp_rd_q[RAW-1:0]);
   assign cmd_head  = cmd_mem_q[cmd_rd_q[CAW-1:0]];
   assign rsp_head  = rsp_mem_q[rsp_rd_q[RAW-1:0]];

`ifdef I2C_SEQ_TIMEOUT_EN
   logic [31:0] wdog_q;
   assign timeout = (state_q == S_WAIT) && !i2c_done_i &&
                    (wdog_q == 32'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   assign wait_done = (state_q == S_WAIT) && i2c_done_i;
   assign flush     = (wait_done && i2c_abort_i) || timeout;
   // Issuing only with a free response slot guarantees the completion can always be stored.
   assign go        = (state_q == S_IDLE) && !cmd_empty && !err_q && !i2c_busy_i && !rsp_full;
   assign cmd_ready_o = rdy_en_q && !cmd_full && !err_q && !flush;
   assign cmd_push  = cmd_valid_i && cmd_ready_o;
   assign rsp_push  = wait_done || timeout;
   assign rsp_wdata = wait_done ? {i2c_rx_data_i, i2c_abort_i} : {32'h0, 1'b1};
   assign rsp_pop   = !rsp_empty && rsp_ready_i;

   always_comb begin
      cmd_wr_d = cmd_wr_q;
      cmd_rd_d = cmd_rd_q;
      if (flush) begin
         cmd_wr_d = '0;
         cmd_rd_d = '0;
      end else begin
         if (cmd_push) cmd_wr_d = cmd_wr_q + (CAW+1)'(1);
         if (go)       cmd_rd_d = cmd_rd_q + (CAW+1)'(1);
      end
   end

   always_comb begin
      rsp_wr_d = rsp_wr_q;
      rsp_rd_d = rsp_rd_q;
      if (rsp_push) rsp_wr_d = rsp_wr_q + (RAW+1)'(1);
      if (rsp_pop)  rsp_rd_d = rsp_rd_q + (RAW+1)'(1);
   end

   always_comb begin
      err_d = err_q;
      if (flush)          err_d = 1'b1;
      else if (err_clr_i) err_d = 1'b0;
   end

   always_ff @(posedge i2c_clock_i) begin
      if (cmd_push) cmd_mem_q[cmd_wr_q[CAW-1:0]] <= {cmd_tx_size_i, cmd_rx_size_i, cmd_tx_data_i};
      if (rsp_push) rsp_mem_q[rsp_wr_q[RAW-1:0]] <= rsp_wdata;
   end

   always_ff @(posedge i2c_clock_i) begin
      if (!i2c_resetn_i) begin
         cmd_wr_q <= '0;
         cmd_rd_q <= '0;
         rsp_wr_q <= '0;
         rsp_rd_q <= '0;
      end else begin
         cmd_wr_q <= cmd_wr_d;
         cmd_rd_q <= cmd_rd_d;
         rsp_wr_q <= rsp_wr_d;
         rsp_rd_q <= rsp_rd_d;
      end
   end

   always_ff @(posedge i2c_clock_i) begin
      if (!i2c_resetn_i) begin
         state_q   <= S_IDLE;
         valid_q   <= 1'b0;
         tx_size_q <= '0;
         rx_size_q <= '0;
         tx_data_q <= '0;
         clkdiv_q  <= '0;
         err_q     <= 1'b0;
         rdy_en_q  <= 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
         wdog_q    <= '0;
`endif
      end else begin
         rdy_en_q <= 1'b1;
         err_q    <= err_d;
         valid_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (go) begin
                  state_q <= S_ISSUE;
                  valid_q <= 1'b1;
                  {tx_size_q, rx_size_q, tx_data_q} <= cmd_head;
                  clkdiv_q <= clkdiv_i;
               end
            end
            S_ISSUE: begin
               state_q <= S_WAIT;
`ifdef I2C_SEQ_TIMEOUT_EN
               wdog_q  <= '0;
`endif
            end
            S_WAIT: begin
               if (rsp_push) begin
                  state_q <= S_IDLE;
               end
`ifdef I2C_SEQ_TIMEOUT_EN
               else begin
                  wdog_q <= wdog_q + 32'd1;
               end
`endif
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign rsp_valid_o   = !rsp_empty;
   assign rsp_rx_data_o = rsp_empty ? 32'h0 : rsp_head[32:1];
   assign rsp_abort_o   = rsp_empty ? 1'b0 : rsp_head[0];
   assign err_o         = err_q;
   assign seq_busy_o    = (state_q != S_IDLE) || !cmd_empty;
   assign i2c_tx_size_o = tx_size_q;
   assign i2c_rx_size_o = rx_size_q;
   assign i2c_tx_data_o = tx_data_q;
   assign i2c_clkdiv_o  = clkdiv_q;
   assign i2c_valid_o   = valid_q;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Bench for i2c_cmd_sequencer: directed scenarios with random payloads, checked against a
// transaction-level model of expected PHY issues and responses.
module tb_i2c_cmd_sequencer;

   logic        clk = 1'b0;
   logic        i2c_resetn_i;
   logic        cmd_valid_i, cmd_ready_o;
   logic [1:0]  cmd_tx_size_i, cmd_rx_size_i;
   logic [31:0] cmd_tx_data_i;
   logic [21:0] clkdiv_i;
   logic        rsp_valid_o, rsp_ready_i;
   logic [31:0] rsp_rx_data_o;
   logic        rsp_abort_o, err_o, err_clr_i, seq_busy_o;
   logic [1:0]  i2c_tx_size_o, i2c_rx_size_o;
   logic [31:0] i2c_tx_data_o;
   logic [21:0] i2c_clkdiv_o;
   logic        i2c_valid_o, i2c_done_i, i2c_busy_i;
   logic [31:0] i2c_rx_data_i;
   logic        i2c_abort_i;

   always #5 clk = ~clk;

   i2c_cmd_sequencer #(.CMD_DEPTH(4), .RSP_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
      .i2c_clock_i(clk), .i2c_resetn_i(i2c_resetn_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_tx_size_i(cmd_tx_size_i), .cmd_rx_size_i(cmd_rx_size_i),
      .cmd_tx_data_i(cmd_tx_data_i), .clkdiv_i(clkdiv_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_rx_data_o(rsp_rx_data_o), .rsp_abort_o(rsp_abort_o),
      .err_o(err_o), .err_clr_i(err_clr_i), .seq_busy_o(seq_busy_o),
      .i2c_tx_size_o(i2c_tx_size_o), .i2c_rx_size_o(i2c_rx_size_o),
      .i2c_tx_data_o(i2c_tx_data_o), .i2c_clkdiv_o(i2c_clkdiv_o),
      .i2c_valid_o(i2c_valid_o), .i2c_done_i(i2c_done_i), .i2c_busy_i(i2c_busy_i),
      .i2c_rx_data_i(i2c_rx_data_i), .i2c_abort_i(i2c_abort_i)
   );

   typedef struct packed {
      logic [1:0]  tx;
      logic [1:0]  rx;
      logic [31:0] data;
      logic [21:0] div;
   } cmd_t;

   cmd_t        exp_cmd[$];
   logic [32:0] exp_rsp[$];
   cmd_t        mon_e;
   logic        mon_prev_valid = 1'b0;
   logic [21:0] cur_div;
   int checks = 0, errors = 0;
   int cyc = 0, issue_cnt = 0, done_cnt = 0, last_issue_cyc = 0;
   int n, p, ti;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Every PHY issue must match the oldest command still expected to be issued.
   always @(negedge clk) begin
      if (i2c_valid_o === 1'b1) begin
         issue_cnt++;
         last_issue_cyc = cyc;
         chk("valid_single_cycle", mon_prev_valid, 1'b0);
         if (exp_cmd.size() == 0) begin
            chk("unexpected_issue", 64'(i2c_tx_data_o), 64'(~i2c_tx_data_o));
         end else begin
            mon_e = exp_cmd.pop_front();
            chk("issue_fields", {i2c_tx_size_o, i2c_rx_size_o, i2c_tx_data_o, i2c_clkdiv_o}, mon_e);
         end
      end
      mon_prev_valid = i2c_valid_o;
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic sample();
      @(negedge clk); #1;
   endtask

   task automatic push(input logic [1:0] tx, input logic [1:0] rx, input logic [31:0] d,
                       input logic exp_acc, output int ncyc);
      cmd_valid_i = 1'b1;
      cmd_tx_size_i = tx;
      cmd_rx_size_i = rx;
      cmd_tx_data_i = d;
      ncyc = cyc;
      sample();
      chk("cmd_ready", cmd_ready_o, exp_acc);
      if (exp_acc) exp_cmd.push_back({tx, rx, d, cur_div});
      tick();
      cmd_valid_i = 1'b0;
   endtask

   task automatic push_rand(input logic exp_acc, output int ncyc);
      push(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom, exp_acc, ncyc);
   endtask

   task automatic wait_issue();
      int k;
      k = 0;
      while (issue_cnt <= done_cnt && k < 60) begin
         tick();
         k++;
      end
      chk("issue_seen", issue_cnt > done_cnt, 1'b1);
   endtask

   task automatic complete(input logic [31:0] rx, input logic ab, input logic clr);
      wait_issue();
      if (issue_cnt > done_cnt) begin
         done_cnt++;
         i2c_done_i = 1'b1;
         i2c_rx_data_i = rx;
         i2c_abort_i = ab;
         err_clr_i = clr;
         sample();
         if (ab) begin
            chk("abort_refuses_push", cmd_ready_o, 1'b0);
            exp_cmd.delete();
         end
         exp_rsp.push_back({rx, ab});
         tick();
         i2c_done_i = 1'b0;
         i2c_abort_i = 1'b0;
         err_clr_i = 1'b0;
      end
   endtask

   task automatic pop_rsp();
      logic [32:0] e;
      rsp_ready_i = 1'b1;
      sample();
      if (exp_rsp.size() == 0) begin
         chk("rsp_unexpected", rsp_valid_o, 1'b0);
      end else begin
         e = exp_rsp.pop_front();
         chk("rsp_valid", rsp_valid_o, 1'b1);
         chk("rsp_entry", {rsp_rx_data_o, rsp_abort_o}, e);
      end
      tick();
      rsp_ready_i = 1'b0;
   endtask

   task automatic reset_chk(input string tag);
      chk(tag, {cmd_ready_o, rsp_valid_o, rsp_abort_o, err_o, seq_busy_o, i2c_valid_o}, 6'b0);
      chk({tag, "_phy"}, {i2c_tx_size_o, i2c_rx_size_o, i2c_tx_data_o, i2c_clkdiv_o}, 58'b0);
      chk({tag, "_rsp"}, rsp_rx_data_o, 32'h0);
   endtask

   task automatic clear_err();
      err_clr_i = 1'b1;
      tick();
      err_clr_i = 1'b0;
      sample();
      chk("err_cleared", err_o, 1'b0);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "time limit exceeded");
   end

   initial begin
      i2c_resetn_i = 1'b0;
      cmd_valid_i = 1'b0; cmd_tx_size_i = '0; cmd_rx_size_i = '0; cmd_tx_data_i = '0;
      rsp_ready_i = 1'b0; err_clr_i = 1'b0;
      i2c_done_i = 1'b0; i2c_busy_i = 1'b0; i2c_rx_data_i = '0; i2c_abort_i = 1'b0;
      cur_div = 22'd250;
      clkdiv_i = cur_div;
      repeat (3) tick();
      sample();
      reset_chk("reset_state");
      tick();
      i2c_resetn_i = 1'b1;
      tick();
      sample();
      chk("ready_after_reset", cmd_ready_o, 1'b1);
      tick();

      // Single command with the reference payload
      push(2'd1, 2'd0, 32'hA5, 1'b1, n);
      complete(32'h5A, 1'b0, 1'b0);
      chk("latency_first", last_issue_cyc, n + 2);
      pop_rsp();

      // Random commands, each with a fresh divider value
      for (int i = 0; i < 4; i++) begin
         cur_div = 22'($urandom);
         clkdiv_i = cur_div;
         push_rand(1'b1, n);
         complete($urandom, 1'b0, 1'b0);
         chk("latency_rand", last_issue_cyc, n + 2);
         pop_rsp();
      end
      sample();
      chk("rsp_drained", rsp_valid_o, 1'b0);
      tick();

      // Response FIFO back-pressure stalls the fifth issue
      for (int i = 0; i < 4; i++) push_rand(1'b1, n);
      for (int i = 0; i < 4; i++) complete($urandom, 1'b0, 1'b0);
      push_rand(1'b1, n);
      repeat (8) tick();
      sample();
      chk("stall_no_issue", issue_cnt, done_cnt);
      chk("stall_busy", seq_busy_o, 1'b1);
      tick();
      p = cyc;
      pop_rsp();
      wait_issue();
      chk("reissue_after_pop", last_issue_cyc, p + 2);
      complete($urandom, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) pop_rsp();

      // Fill the command FIFO, then pop and push around the full point
      i2c_busy_i = 1'b1;
      for (int i = 0; i < 4; i++) push_rand(1'b1, n);
      sample();
      chk("full_not_ready", cmd_ready_o, 1'b0);
      tick();
      push_rand(1'b0, n);
      cmd_valid_i = 1'b1;
      cmd_tx_size_i = 2'd3; cmd_rx_size_i = 2'd2; cmd_tx_data_i = $urandom;
      i2c_busy_i = 1'b0;
      sample();
      chk("full_pop_cycle_ready", cmd_ready_o, 1'b0);
      tick();
      sample();
      chk("ready_after_pop", cmd_ready_o, 1'b1);
      exp_cmd.push_back({cmd_tx_size_i, cmd_rx_size_i, cmd_tx_data_i, cur_div});
      tick();
      cmd_valid_i = 1'b0;
      sample();
      chk("full_again", cmd_ready_o, 1'b0);
      tick();
      for (int i = 0; i < 5; i++) begin
         complete($urandom, 1'b0, 1'b0);
         pop_rsp();
      end

      // Abort flushes queued commands and latches the error
      i2c_busy_i = 1'b1;
      for (int i = 0; i < 3; i++) push_rand(1'b1, n);
      i2c_busy_i = 1'b0;
      complete($urandom, 1'b1, 1'b0);
      sample();
      chk("abort_err", err_o, 1'b1);
      chk("abort_ready", cmd_ready_o, 1'b0);
      chk("abort_flushed", seq_busy_o, 1'b0);
      tick();
      repeat (6) tick();
      sample();
      chk("abort_no_issue", issue_cnt, done_cnt);
      tick();
      push_rand(1'b0, n);
      pop_rsp();
      clear_err();
      sample();
      chk("ready_after_clear", cmd_ready_o, 1'b1);
      tick();
      push_rand(1'b1, n);
      complete($urandom, 1'b0, 1'b0);
      chk("latency_after_clear", last_issue_cyc, n + 2);
      pop_rsp();

      // Error set wins over a simultaneous clear
      push_rand(1'b1, n);
      complete($urandom, 1'b1, 1'b1);
      sample();
      chk("set_wins_clear", err_o, 1'b1);
      tick();
      pop_rsp();
      clear_err();

      // Done outside WAIT is ignored
      i2c_done_i = 1'b1; i2c_abort_i = 1'b1; i2c_rx_data_i = $urandom;
      tick();
      i2c_done_i = 1'b0; i2c_abort_i = 1'b0;
      sample();
      chk("stray_done_err", err_o, 1'b0);
      chk("stray_done_rsp", rsp_valid_o, 1'b0);
      tick();

      // Reset while waiting on the PHY
      push_rand(1'b1, n);
      complete($urandom, 1'b0, 1'b0);
      push_rand(1'b1, n);
      push_rand(1'b1, n);
      wait_issue();
      repeat (2) tick();
      i2c_resetn_i = 1'b0;
      tick();
      sample();
      reset_chk("reset_mid_wait");
      exp_cmd.delete();
      exp_rsp.delete();
      done_cnt = issue_cnt;
      tick();
      i2c_resetn_i = 1'b1;
      tick();
      sample();
      chk("ready_after_reset2", cmd_ready_o, 1'b1);
      tick();
      repeat (5) tick();
      sample();
      chk("reset_no_issue", issue_cnt, done_cnt);
      chk("reset_rsp_empty", rsp_valid_o, 1'b0);
      tick();

`ifdef I2C_SEQ_TIMEOUT_EN
      // Watchdog: PHY never answers
      push_rand(1'b1, n);
      wait_issue();
      ti = last_issue_cyc;
      while (cyc < ti + 16) tick();
      sample();
      chk("wdog_not_yet", rsp_valid_o, 1'b0);
      tick();
      sample();
      chk("wdog_rsp_valid", rsp_valid_o, 1'b1);
      chk("wdog_err", err_o, 1'b1);
      chk("wdog_ready", cmd_ready_o, 1'b0);
      exp_rsp.push_back({32'h0, 1'b1});
      done_cnt++;
      tick();
      clear_err();
      i2c_done_i = 1'b1; i2c_abort_i = 1'b1; i2c_rx_data_i = $urandom;
      tick();
      i2c_done_i = 1'b0; i2c_abort_i = 1'b0;
      sample();
      chk("wdog_stray_done", err_o, 1'b0);
      tick();
      pop_rsp();
      sample();
      chk("wdog_rsp_single", rsp_valid_o, 1'b0);
      tick();
      push_rand(1'b1, n);
      wait_issue();
      repeat (5) tick();
      i2c_resetn_i = 1'b0;
      tick();
      sample();
      reset_chk("wdog_reset_mid_wait");
      exp_cmd.delete();
      exp_rsp.delete();
      done_cnt = issue_cnt;
      tick();
      i2c_resetn_i = 1'b1;
      repeat (2) tick();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
